// File: rtl/sparse_pair_issuer_pkg.sv
// sparse_pair_issuer_pkg: shared state encoding and dp_unit latency for the sparse issue lane.
// Rev 1.0
`default_nettype none

package sparse_pair_issuer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MERGE   = 3'd1,
    S_DRAIN_A = 3'd2,
    S_DRAIN_B = 3'd3,
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int DP_LATENCY = 2;

endpackage

`default_nettype wire

// File: rtl/sparse_pair_issuer_tag_pipe.sv
// issue_tag_pipe: enable-gated valid shift register that tracks issues through the dp_unit.
// Rev 1.0
`default_nettype none

module issue_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stages <= '0;
    end else if (enable) begin
      stages <= {stages[DEPTH-2:0], in_valid};
    end
  end

  assign out_valid = stages[DEPTH-1];
  assign empty     = ~|stages;

endmodule

`default_nettype wire

// File: rtl/sparse_pair_issuer.sv
// sparse_pair_issuer: index-intersection merge of two compressed sparse vectors feeding a dp_unit.
// Rev 1.0
`default_nettype none

module sparse_pair_issuer
  import sparse_pair_issuer_pkg::*;
#(
  parameter int DW_DATA  = 8,
  parameter int DW_INDEX = 8,
  parameter int MAX_NNZ  = 256,
  localparam int CW      = $clog2(MAX_NNZ + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [DW_DATA-1:0]  a_value,
  input  logic [DW_INDEX-1:0] a_index,
  input  logic                a_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [DW_DATA-1:0]  b_value,
  input  logic [DW_INDEX-1:0] b_index,
  input  logic                b_last,
  input  logic                acc_ready,
  output logic                dp_enable,
  output logic [DW_DATA-1:0]  dp_a,
  output logic [DW_DATA-1:0]  dp_b,
  output logic [1:0]          dp_valid,
  output logic                prod_valid,
  output logic                vec_done,
  output logic [CW-1:0]       match_count
);

  state_t state, state_nxt;
  logic   issue;
  logic   pipe_empty;
  logic   both_heads;
  logic   a_end, b_end;

  assign both_heads = a_valid & b_valid & acc_ready;
  assign dp_enable  = acc_ready;

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    issue     = 1'b0;
    a_end     = 1'b0;
    b_end     = 1'b0;
    case (state)
      S_IDLE: begin
        if (both_heads) state_nxt = S_MERGE;
      end
      S_MERGE: begin
        if (both_heads) begin
          if (a_index == b_index) begin
            a_ready = 1'b1;
            b_ready = 1'b1;
            issue   = 1'b1;
          end else if (a_index < b_index) begin
            a_ready = 1'b1;
          end else begin
            b_ready = 1'b1;
          end
          a_end = a_ready & a_last;
          b_end = b_ready & b_last;
          if (a_end && b_end)  state_nxt = S_FLUSH;
          else if (a_end)      state_nxt = S_DRAIN_B;
          else if (b_end)      state_nxt = S_DRAIN_A;
        end
      end
      // Leftover entries of the longer vector are consumed without issuing.
      S_DRAIN_A: begin
        a_ready = acc_ready;
        if (a_valid && acc_ready && a_last) state_nxt = S_FLUSH;
      end
      S_DRAIN_B: begin
        b_ready = acc_ready;
        if (b_valid && acc_ready && b_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (acc_ready && pipe_empty) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (acc_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dp_a     = issue ? a_value : '0;
  assign dp_b     = issue ? b_value : '0;
  assign dp_valid = {2{issue}};
  assign vec_done = (state == S_DONE) & acc_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      match_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        match_count <= '0;
      end else if (issue && (match_count != {CW{1'b1}})) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

  issue_tag_pipe #(
    .DEPTH (DP_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (acc_ready),
    .in_valid  (issue),
    .out_valid (prod_valid),
    .empty     (pipe_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_sparse_pair_issuer.sv
// tb_sparse_pair_issuer: directed vector table plus reset and back-to-back sequences.
// Rev 1.0
`default_nettype none

module tb_sparse_pair_issuer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] a_value = '0, b_value = '0, a_index = '0, b_index = '0;
  logic       a_last = 1'b0, b_last = 1'b0;
  logic       acc_ready = 1'b1;
  logic       dp_enable;
  logic [7:0] dp_a, dp_b;
  logic [1:0] dp_valid;
  logic       prod_valid, vec_done;
  logic [8:0] match_count;

  int errors = 0;
  int checks = 0;

  sparse_pair_issuer #(.DW_DATA(8), .DW_INDEX(8), .MAX_NNZ(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_value(a_value), .a_index(a_index), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_value(b_value), .b_index(b_index), .b_last(b_last),
    .acc_ready(acc_ready), .dp_enable(dp_enable), .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid),
    .prod_valid(prod_valid), .vec_done(vec_done), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // Behavioural dp_unit: 2-cycle enable-gated multiply, truncated to 8 bits.
  logic [7:0] m0, m1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else if (dp_enable) begin
      m0 <= (dp_valid == 2'b11) ? dp_a * dp_b : 8'd0;
      m1 <= m0;
    end
  end

  typedef struct {
    int         na, nb;
    logic [7:0] ai[4], av[4], bi[4], bv[4];
    int         stall_at, stall_len;
    int         exp_mc, exp_lat, nprod;
    logic [7:0] prod[4];
  } vec_t;

  vec_t vec[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; acc_ready = 1'b1;
    end
  endtask

  task automatic run_vec(input int t, input int abort_at);
    int ap = 0, bp = 0, cyc = 0, nseen = 0, issues = 0;
    bit done = 0, stalled, pa, pb;
    logic prev_pv = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      a_valid = (ap < vec[t].na);
      b_valid = (bp < vec[t].nb);
      a_index = a_valid ? vec[t].ai[ap] : 8'd0;
      a_value = a_valid ? vec[t].av[ap] : 8'd0;
      a_last  = a_valid && (ap == vec[t].na - 1);
      b_index = b_valid ? vec[t].bi[bp] : 8'd0;
      b_value = b_valid ? vec[t].bv[bp] : 8'd0;
      b_last  = b_valid && (bp == vec[t].nb - 1);
      stalled = (cyc >= vec[t].stall_at) && (cyc < vec[t].stall_at + vec[t].stall_len);
      acc_ready = !stalled;
      #1;
      if (cyc == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_prod_valid", prod_valid, 0);
        chk("rst_match_count", match_count, 0);
        return;
      end
      if (stalled) begin
        chk("stall_a_ready", a_ready, 0);
        chk("stall_b_ready", b_ready, 0);
        chk("stall_dp_valid", dp_valid, 0);
        chk("stall_dp_enable", dp_enable, 0);
        chk("stall_prod_hold", prod_valid, prev_pv);
      end
      if (dp_valid == 2'b11) issues++;
      if (prod_valid) begin
        if (nseen < vec[t].nprod) chk("product", m1, vec[t].prod[nseen]);
        else chk("extra_product", 1, 0);
        nseen++;
      end
      if (vec_done) begin
        chk("match_count", match_count, vec[t].exp_mc);
        chk("done_latency", cyc, vec[t].exp_lat);
        done = 1;
      end
      pa = a_valid & a_ready;
      pb = b_valid & b_ready;
      prev_pv = prod_valid;
      @(posedge clk);
      ap += int'(pa);
      bp += int'(pb);
      cyc++;
    end
    chk("vec_done_seen", int'(done), 1);
    chk("issue_count", issues, vec[t].exp_mc);
    chk("product_count", nseen, vec[t].nprod);
    chk("a_pops", ap, vec[t].na);
    chk("b_pops", bp, vec[t].nb);
  endtask

  initial begin
    // Two matches at indices 3 and 5.
    vec[0].na = 3; vec[0].ai = '{8'd1, 8'd3, 8'd5, 8'd0}; vec[0].av = '{8'd2, 8'd3, 8'd4, 8'd0};
    vec[0].nb = 3; vec[0].bi = '{8'd3, 8'd5, 8'd7, 8'd0}; vec[0].bv = '{8'd10, 8'hFF, 8'd6, 8'd0};
    vec[0].stall_at = -1; vec[0].stall_len = 0;
    vec[0].exp_mc = 2; vec[0].exp_lat = 7; vec[0].nprod = 2;
    vec[0].prod = '{8'd30, 8'hFC, 8'd0, 8'd0};
    // Disjoint index sets.
    vec[1].na = 2; vec[1].ai = '{8'd0, 8'd2, 8'd0, 8'd0}; vec[1].av = '{8'd1, 8'd1, 8'd0, 8'd0};
    vec[1].nb = 2; vec[1].bi = '{8'd1, 8'd3, 8'd0, 8'd0}; vec[1].bv = '{8'd1, 8'd1, 8'd0, 8'd0};
    vec[1].stall_at = -1; vec[1].stall_len = 0;
    vec[1].exp_mc = 0; vec[1].exp_lat = 6; vec[1].nprod = 0;
    vec[1].prod = '{8'd0, 8'd0, 8'd0, 8'd0};
    // First case with a 3-cycle stall right after the first issue.
    vec[2] = vec[0];
    vec[2].stall_at = 3; vec[2].stall_len = 3; vec[2].exp_lat = 10;
    // Single match, then B drained.
    vec[3].na = 1; vec[3].ai = '{8'd0, 8'd0, 8'd0, 8'd0}; vec[3].av = '{8'd5, 8'd0, 8'd0, 8'd0};
    vec[3].nb = 3; vec[3].bi = '{8'd0, 8'd4, 8'd9, 8'd0}; vec[3].bv = '{8'd2, 8'd1, 8'd1, 8'd0};
    vec[3].stall_at = -1; vec[3].stall_len = 0;
    vec[3].exp_mc = 1; vec[3].exp_lat = 5; vec[3].nprod = 1;
    vec[3].prod = '{8'd10, 8'd0, 8'd0, 8'd0};

    // Reset state, with both heads valid so ready must be held low by reset alone.
    a_valid = 1'b1; b_valid = 1'b1;
    #12;
    chk("init_a_ready", a_ready, 0);
    chk("init_dp_valid", dp_valid, 0);
    chk("init_prod_valid", prod_valid, 0);
    chk("init_vec_done", vec_done, 0);
    chk("init_match_count", match_count, 0);
    idle(1);
    reset_n = 1'b1;
    idle(2);

    for (int t = 0; t < 4; t++) begin
      run_vec(t, -1);
      idle(2);
    end

    // Reset asserted between edges during MERGE, then a clean rerun.
    run_vec(0, 3);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    run_vec(0, -1);
    idle(2);

    // Back-to-back vectors: the second is presented the cycle after vec_done.
    run_vec(0, -1);
    run_vec(3, -1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
